fan_duty_sched: RTL and testbench

//  Per-fan duty scheduler that sits in front of the fan PWM/tach block.

---
 rtl/fan_pkg.sv | 28 ++
 rtl/fan_duty_sched_if.sv | 31 +++
 rtl/fan_duty_ramp.sv | 47 ++++
 rtl/fan_duty_sched.sv | 148 ++++++++++++++
 tb/tb_fan_duty_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fan_pkg.sv
// Shared types and constants for the per-fan duty scheduler.
package fan_pkg;

    localparam int unsigned DUTY_W = 8;
    localparam int unsigned TACH_W = 11;
    localparam int unsigned WIN_W  = 3;
    localparam int unsigned SPIN_W = 4;

    typedef enum logic [1:0] {
        FAN_ST_IDLE   = 2'd0,
        FAN_ST_SPINUP = 2'd1,
        FAN_ST_RUN    = 2'd2,
        FAN_ST_FAIL   = 2'd3
    } fan_state_e;

    localparam logic [DUTY_W-1:0] FAN_DUTY_MAX = 8'd255;
    localparam logic [DUTY_W-1:0] FAN_DUTY_OFF = 8'd0;

    // Window counters stick at all-ones instead of wrapping.
    function automatic logic [WIN_W-1:0] sat_inc_win(input logic [WIN_W-1:0] v);
        return (v == {WIN_W{1'b1}}) ? v : v + WIN_W'(1);
    endfunction

    function automatic logic [SPIN_W-1:0] sat_inc_spin(input logic [SPIN_W-1:0] v);
        return (v == {SPIN_W{1'b1}}) ? v : v + SPIN_W'(1);
    endfunction

endpackage

// File: rtl/fan_duty_sched_if.sv
// Control/status bundle between the fan scheduler and its host.
interface fan_duty_sched_if;
    import fan_pkg::*;

    logic                tick_ramp;
    logic                tach_vld;
    logic                fan_present;
    logic [DUTY_W-1:0]   duty_req;
    logic                ovr_en;
    logic [DUTY_W-1:0]   ovr_duty;
    logic [TACH_W-1:0]   tach0_cnt;
    logic [TACH_W-1:0]   tach1_cnt;
    logic                dual_rotor;
    logic [DUTY_W-1:0]   pwm_duty;
    logic [1:0]          state;
    logic                fan_fail;
    logic                ramp_busy;

    modport master (
        output tick_ramp, tach_vld, fan_present, duty_req, ovr_en, ovr_duty,
               tach0_cnt, tach1_cnt, dual_rotor,
        input  pwm_duty, state, fan_fail, ramp_busy
    );

    modport slave (
        input  tick_ramp, tach_vld, fan_present, duty_req, ovr_en, ovr_duty,
               tach0_cnt, tach1_cnt, dual_rotor,
        output pwm_duty, state, fan_fail, ramp_busy
    );

endinterface

// File: rtl/fan_duty_ramp.sv
// Current-duty register: forced load for fixed duties, otherwise a rate-limited
// step toward target on each enabled ramp tick.
module fan_duty_ramp
    import fan_pkg::*;
#(
    parameter logic [DUTY_W-1:0] RAMP_STEP = 8'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DUTY_W-1:0] load_val,
    input  logic              step_en,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] duty_nxt_c
);

    logic [DUTY_W:0] cur9;
    logic [DUTY_W:0] tgt9;
    logic [DUTY_W:0] diff9;
    logic [DUTY_W:0] step9;
    logic            up;

    // 9-bit magnitude keeps the step from wrapping or overshooting.
    always_comb begin
        cur9       = {1'b0, duty};
        tgt9       = {1'b0, target};
        up         = (tgt9 >= cur9);
        diff9      = up ? (tgt9 - cur9) : (cur9 - tgt9);
        step9      = (diff9 > {1'b0, RAMP_STEP}) ? {1'b0, RAMP_STEP} : diff9;
        duty_nxt_c = duty;
        if (load) begin
            duty_nxt_c = load_val;
        end else if (step_en) begin
            duty_nxt_c = up ? DUTY_W'(cur9 + step9) : DUTY_W'(cur9 - step9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= FAN_DUTY_OFF;
        end else begin
            duty <= duty_nxt_c;
        end
    end

endmodule

// File: rtl/fan_duty_sched.sv
// Per-fan duty scheduler: source select, spin-up sequencing, ramp limiting,
// minimum duty floor and tach-based stall detection with forced full speed.
module fan_duty_sched
    import fan_pkg::*;
#(
    parameter logic [DUTY_W-1:0] SPINUP_DUTY = 8'd255,
    parameter int unsigned       SPINUP_SEC  = 3,
    parameter logic [DUTY_W-1:0] MIN_DUTY    = 8'd51,
    parameter logic [DUTY_W-1:0] RAMP_STEP   = 8'd4,
    parameter logic [TACH_W-1:0] MIN_TACH    = 11'd20,
    parameter int unsigned       STALL_WIN   = 3,
    parameter int unsigned       RECOVER_WIN = 5
) (
    input  logic            clk,
    input  logic            rst,
    fan_duty_sched_if.slave bus
);

    localparam logic [SPIN_W-1:0] SPIN_LAST  = SPIN_W'(SPINUP_SEC);
    localparam logic [WIN_W-1:0]  STALL_LAST = WIN_W'(STALL_WIN);
    localparam logic [WIN_W-1:0]  GOOD_LAST  = WIN_W'(RECOVER_WIN);

    fan_state_e        state;
    fan_state_e        state_nxt;
    logic [SPIN_W-1:0] spin_cnt;
    logic [SPIN_W-1:0] spin_nxt;
    logic [WIN_W-1:0]  stall_cnt;
    logic [WIN_W-1:0]  stall_nxt;
    logic [WIN_W-1:0]  good_cnt;
    logic [WIN_W-1:0]  good_nxt;
    logic              tach_ok;
    logic              load;
    logic [DUTY_W-1:0] load_val;
    logic              step_en;
    logic [DUTY_W-1:0] sel_duty;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_nxt;

    assign sel_duty = bus.ovr_en ? bus.ovr_duty : bus.duty_req;
    assign target   = (sel_duty < MIN_DUTY) ? MIN_DUTY : sel_duty;
    assign tach_ok  = (bus.tach0_cnt >= MIN_TACH) &&
                      (!bus.dual_rotor || (bus.tach1_cnt >= MIN_TACH));

    // Next state, window counters and duty-register control.
    always_comb begin
        state_nxt = state;
        spin_nxt  = spin_cnt;
        stall_nxt = stall_cnt;
        good_nxt  = good_cnt;
        load      = 1'b0;
        load_val  = FAN_DUTY_OFF;
        step_en   = 1'b0;
        if (!bus.fan_present) begin
            state_nxt = FAN_ST_IDLE;
            spin_nxt  = '0;
            stall_nxt = '0;
            good_nxt  = '0;
            load      = 1'b1;
            load_val  = FAN_DUTY_OFF;
        end else begin
            case (state)
                FAN_ST_IDLE: begin
                    state_nxt = FAN_ST_SPINUP;
                    spin_nxt  = '0;
                    stall_nxt = '0;
                    good_nxt  = '0;
                    load      = 1'b1;
                    load_val  = SPINUP_DUTY;
                end
                FAN_ST_SPINUP: begin
                    load     = 1'b1;
                    load_val = SPINUP_DUTY;
                    if (bus.tach_vld) begin
                        spin_nxt = sat_inc_spin(spin_cnt);
                        if (spin_nxt >= SPIN_LAST) begin
                            spin_nxt  = '0;
                            stall_nxt = '0;
                            good_nxt  = '0;
                            state_nxt = tach_ok ? FAN_ST_RUN : FAN_ST_FAIL;
                            load_val  = tach_ok ? SPINUP_DUTY : FAN_DUTY_MAX;
                        end
                    end
                end
                FAN_ST_RUN: begin
                    step_en = bus.tick_ramp;
                    if (bus.tach_vld) begin
                        stall_nxt = tach_ok ? '0 : sat_inc_win(stall_cnt);
                        if (stall_nxt >= STALL_LAST) begin
                            state_nxt = FAN_ST_FAIL;
                            stall_nxt = '0;
                            good_nxt  = '0;
                            load      = 1'b1;
                            load_val  = FAN_DUTY_MAX;
                        end
                    end
                end
                default: begin
                    load     = 1'b1;
                    load_val = FAN_DUTY_MAX;
                    if (bus.tach_vld) begin
                        good_nxt = tach_ok ? sat_inc_win(good_cnt) : '0;
                        if (good_nxt >= GOOD_LAST) begin
                            state_nxt = FAN_ST_RUN;
                            good_nxt  = '0;
                            stall_nxt = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FAN_ST_IDLE;
            spin_cnt      <= '0;
            stall_cnt     <= '0;
            good_cnt      <= '0;
            bus.fan_fail  <= 1'b0;
            bus.ramp_busy <= 1'b0;
        end else begin
            state         <= state_nxt;
            spin_cnt      <= spin_nxt;
            stall_cnt     <= stall_nxt;
            good_cnt      <= good_nxt;
            bus.fan_fail  <= (state_nxt == FAN_ST_FAIL);
            bus.ramp_busy <= (state_nxt == FAN_ST_RUN) && (duty_nxt != target);
        end
    end

    fan_duty_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .step_en    (step_en),
        .target     (target),
        .duty       (duty),
        .duty_nxt_c (duty_nxt)
    );

    assign bus.state    = state;
    assign bus.pwm_duty = duty;

endmodule

// File: tb/tb_fan_duty_sched.sv
// Scenario bench for fan_duty_sched with a cycle-level behavioural model.
module tb_fan_duty_sched;
    import fan_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fan_duty_sched_if bus();

    fan_duty_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int m_st, m_duty, m_spin, m_stall, m_good;
    bit m_fail, m_busy;

    // Reference: state rules applied with plain integer arithmetic on the inputs seen before the edge.
    task automatic model_step();
        int tgt;
        int d;
        bit ok;
        tgt = bus.ovr_en ? int'(bus.ovr_duty) : int'(bus.duty_req);
        if (tgt < 51) tgt = 51;
        ok = (int'(bus.tach0_cnt) >= 20) && (!bus.dual_rotor || int'(bus.tach1_cnt) >= 20);
        if (rst) begin
            m_st = 0; m_duty = 0; m_spin = 0; m_stall = 0; m_good = 0; m_fail = 0; m_busy = 0;
            return;
        end
        if (!bus.fan_present) begin
            m_st = 0; m_duty = 0; m_spin = 0; m_stall = 0; m_good = 0;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_duty = 255; m_spin = 0; m_stall = 0; m_good = 0; end
                1: begin
                    m_duty = 255;
                    if (bus.tach_vld) begin
                        m_spin++;
                        if (m_spin == 3) begin
                            m_spin = 0; m_stall = 0; m_good = 0;
                            m_st = ok ? 2 : 3;
                        end
                    end
                end
                2: begin
                    if (bus.tick_ramp) begin
                        d = tgt - m_duty;
                        if (d > 4) d = 4;
                        if (d < -4) d = -4;
                        m_duty += d;
                    end
                    if (bus.tach_vld) begin
                        if (ok) m_stall = 0; else m_stall++;
                        if (m_stall == 3) begin m_st = 3; m_duty = 255; m_stall = 0; m_good = 0; end
                    end
                end
                default: begin
                    m_duty = 255;
                    if (bus.tach_vld) begin
                        if (ok) begin
                            m_good++;
                            if (m_good == 5) begin m_st = 2; m_good = 0; m_stall = 0; end
                        end else m_good = 0;
                    end
                end
            endcase
        end
        m_fail = (m_st == 3);
        m_busy = (m_st == 2) && (m_duty != tgt);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic window();
        repeat (3) step();
        bus.tach_vld = 1'b1;
        step();
        bus.tach_vld = 1'b0;
    endtask

    task automatic tick();
        bus.tick_ramp = 1'b1;
        step();
        bus.tick_ramp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fan_present = 1'b0;
        step(); step();
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        total++; if (bus.pwm_duty !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", bus.pwm_duty); end
        total++; if (bus.fan_fail !== 1'b0 || bus.ramp_busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", bus.fan_fail, bus.ramp_busy); end
        rst = 1'b0;
        step();
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL idle_absent got=%0d exp=0", bus.state); end
    endtask

    task automatic test_spinup_ramp();
        int n;
        bus.fan_present = 1'b1; bus.tach0_cnt = 11'd100; bus.duty_req = 8'd80;
        step();
        total++; if (bus.state !== 2'd1 || bus.pwm_duty !== 8'd255) begin
            bad++; $display("FAIL spin_enter got=%0d/%0d exp=1/255", bus.state, bus.pwm_duty); end
        window(); window();
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL spin_hold got=%0d exp=1", bus.state); end
        window();
        total++; if (bus.state !== 2'd2 || bus.pwm_duty !== 8'd255) begin
            bad++; $display("FAIL run_enter got=%0d/%0d exp=2/255", bus.state, bus.pwm_duty); end
        total++; if (bus.ramp_busy !== 1'b1) begin bad++; $display("FAIL busy_enter got=%b exp=1", bus.ramp_busy); end
        tick();
        total++; if (bus.pwm_duty !== 8'd251) begin bad++; $display("FAIL first_tick got=%0d exp=251", bus.pwm_duty); end
        n = 1;
        while (bus.pwm_duty !== 8'd80 && n < 100) begin tick(); n++; end
        total++; if (n != 44) begin bad++; $display("FAIL ramp_ticks got=%0d exp=44", n); end
        total++; if (bus.ramp_busy !== 1'b0) begin bad++; $display("FAIL busy_settled got=%b exp=0", bus.ramp_busy); end
    endtask

    task automatic test_min_floor();
        bus.duty_req = 8'd10;
        repeat (7) tick();
        total++; if (bus.pwm_duty !== 8'd52 || bus.ramp_busy !== 1'b1) begin
            bad++; $display("FAIL floor_pre got=%0d/%b exp=52/1", bus.pwm_duty, bus.ramp_busy); end
        tick();
        total++; if (bus.pwm_duty !== 8'd51 || bus.ramp_busy !== 1'b0) begin
            bad++; $display("FAIL floor_hit got=%0d/%b exp=51/0", bus.pwm_duty, bus.ramp_busy); end
        repeat (3) tick();
        total++; if (bus.pwm_duty !== 8'd51) begin bad++; $display("FAIL floor_hold got=%0d exp=51", bus.pwm_duty); end
    endtask

    task automatic test_stall_recover();
        bus.tach0_cnt = 11'd5;
        window(); window();
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL stall_pre got=%0d exp=2", bus.state); end
        window();
        total++; if (bus.state !== 2'd3 || bus.pwm_duty !== 8'd255 || bus.fan_fail !== 1'b1) begin
            bad++; $display("FAIL stall_fail got=%0d/%0d/%b exp=3/255/1", bus.state, bus.pwm_duty, bus.fan_fail); end
        bus.tach0_cnt = 11'd100;
        repeat (4) window();
        total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL recover_pre got=%0d exp=3", bus.state); end
        window();
        total++; if (bus.state !== 2'd2 || bus.fan_fail !== 1'b0 || bus.pwm_duty !== 8'd255) begin
            bad++; $display("FAIL recover_run got=%0d/%b/%0d exp=2/0/255", bus.state, bus.fan_fail, bus.pwm_duty); end
    endtask

    task automatic test_dual_rotor();
        for (int k = 0; k < 2; k++) begin
            bus.fan_present = 1'b0; step();
            bus.fan_present = 1'b1; step();
            bus.dual_rotor = (k == 0); bus.tach0_cnt = 11'd100; bus.tach1_cnt = 11'd0;
            window(); window(); window();
            total++; if (bus.state !== ((k == 0) ? 2'd3 : 2'd2)) begin
                bad++; $display("FAIL dual_%0d got=%0d exp=%0d", k, bus.state, (k == 0) ? 3 : 2); end
        end
        bus.dual_rotor = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        bus.duty_req = 8'd120; bus.tach0_cnt = 11'd100;
        n = 0;
        while (bus.pwm_duty !== 8'd120 && n < 100) begin tick(); n++; end
        total++; if (bus.pwm_duty !== 8'd120) begin bad++; $display("FAIL reach_120 got=%0d exp=120", bus.pwm_duty); end
        bus.ovr_en = 1'b1; bus.ovr_duty = 8'd200; bus.tick_ramp = 1'b1; bus.tach_vld = 1'b1;
        step();
        bus.tick_ramp = 1'b0; bus.tach_vld = 1'b0;
        total++; if (bus.pwm_duty !== 8'd124 || bus.state !== 2'd2) begin
            bad++; $display("FAIL ovr_same_cycle got=%0d/%0d exp=124/2", bus.pwm_duty, bus.state); end
        bus.fan_present = 1'b0;
        step();
        total++; if (bus.state !== 2'd0 || bus.pwm_duty !== 8'd0) begin
            bad++; $display("FAIL absent_idle got=%0d/%0d exp=0/0", bus.state, bus.pwm_duty); end
        bus.ovr_en = 1'b0;
    endtask

    task automatic test_mid_spinup_reset();
        bus.fan_present = 1'b1; bus.tach0_cnt = 11'd100;
        step(); window();
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (bus.state !== 2'd0 || bus.pwm_duty !== 8'd0) begin
            bad++; $display("FAIL spin_rst got=%0d/%0d exp=0/0", bus.state, bus.pwm_duty); end
        step();
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL spin_reenter got=%0d exp=1", bus.state); end
        window(); window();
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL spin_restart got=%0d exp=1", bus.state); end
        window();
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL spin_done got=%0d exp=2", bus.state); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 499) == 0);
            bus.fan_present = ($urandom_range(0, 149) != 0);
            bus.tick_ramp   = ($urandom_range(0, 2) == 0);
            bus.tach_vld    = ($urandom_range(0, 3) == 0);
            bus.duty_req    = 8'($urandom_range(0, 255));
            bus.ovr_en      = ($urandom_range(0, 3) == 0);
            bus.ovr_duty    = 8'($urandom_range(0, 255));
            bus.tach0_cnt   = 11'($urandom_range(0, 45));
            bus.tach1_cnt   = 11'($urandom_range(0, 45));
            bus.dual_rotor  = $urandom_range(0, 1) == 1;
            step();
            total++; if (bus.state !== 2'(m_st) || bus.pwm_duty !== 8'(m_duty)) begin
                bad++; $display("FAIL rnd_%0d st/duty got=%0d/%0d exp=%0d/%0d", c, bus.state, bus.pwm_duty, m_st, m_duty); end
            total++; if (bus.fan_fail !== m_fail || bus.ramp_busy !== m_busy) begin
                bad++; $display("FAIL rnd_%0d fail/busy got=%b%b exp=%b%b", c, bus.fan_fail, bus.ramp_busy, m_fail, m_busy); end
        end
        rst = 1'b0;
        bus.tick_ramp = 1'b0; bus.tach_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.tick_ramp = 1'b0; bus.tach_vld = 1'b0; bus.fan_present = 1'b0;
        bus.duty_req = 8'd0; bus.ovr_en = 1'b0; bus.ovr_duty = 8'd0;
        bus.tach0_cnt = 11'd0; bus.tach1_cnt = 11'd0; bus.dual_rotor = 1'b0;
        m_st = 0; m_duty = 0; m_spin = 0; m_stall = 0; m_good = 0; m_fail = 0; m_busy = 0;
        test_reset();
        test_spinup_ramp();
        test_min_floor();
        test_stall_recover();
        test_dual_rotor();
        test_back_to_back();
        test_mid_spinup_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
